// File: rtl/mcpu_core_dcache_pkg.sv
// Shared definitions for the mcpu data cache: state encodings, tag sizing and helpers.
package mcpu_core_dcache_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FILL  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_WDONE = 2'd3;

   localparam logic [3:0] DC_RD_MASK = 4'b0000;

   function automatic int unsigned dc_tag_bits(int unsigned idx_bits);
      return 30 - idx_bits;
   endfunction

   function automatic logic [31:0] sat_inc(logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/mcpu_core_dcache_array.sv
// Direct-mapped line storage: valid/tag/data flops, asynchronous read, byte-enable write.
module mcpu_core_dcache_array
   import mcpu_core_dcache_pkg::*;
#(
   parameter int unsigned IDX_BITS = 6
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [IDX_BITS-1:0]               rd_idx_i,
   output logic                              rd_valid_o,
   output logic [dc_tag_bits(IDX_BITS)-1:0]  rd_tag_o,
   output logic [31:0]                       rd_data_o,
   input  logic                              wr_en_i,
   input  logic                              wr_fill_i,
   input  logic [IDX_BITS-1:0]               wr_idx_i,
   input  logic [3:0]                        wr_be_i,
   input  logic [dc_tag_bits(IDX_BITS)-1:0]  wr_tag_i,
   input  logic [31:0]                       wr_data_i
);

   localparam int unsigned LINES    = 1 << IDX_BITS;
   localparam int unsigned TAG_BITS = dc_tag_bits(IDX_BITS);

   logic [LINES-1:0]    valid_q;
   logic [TAG_BITS-1:0] tag_q  [LINES];
   logic [31:0]         data_q [LINES];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
      end else if (wr_en_i && wr_fill_i) begin
         valid_q[wr_idx_i] <= 1'b1;
      end
   end

   // Tag only changes on a fill; a write hit merges bytes into the resident line.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         if (wr_fill_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
         end
         for (int b = 0; b < 4; b++) begin
            if (wr_be_i[b]) begin
               data_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
            end
         end
      end
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/mcpu_core_dcache.sv
// Direct-mapped write-through, no-write-allocate data cache on the mem2dc port.
// Optional hit/miss counters are built when MCPU_DCACHE_STATS_EN is defined.
module mcpu_core_dcache
   import mcpu_core_dcache_pkg::*;
#(
   parameter int unsigned IDX_BITS = 6
) (
   input  logic         clkrst_core_clk,
   input  logic         clkrst_core_rst_n,
   input  logic [29:0]  mem2dc_paddr,
   input  logic [3:0]   mem2dc_write,
   input  logic         mem2dc_valid,
   output logic         mem2dc_done,
   inout  wire  [31:0]  mem2dc_data,
   output logic [29:0]  dc2mem_addr,
   output logic         dc2mem_rd_req,
   output logic         dc2mem_wr_req,
   output logic [3:0]   dc2mem_wmask,
   output logic [31:0]  dc2mem_wdata,
   input  logic         dc2mem_ack,
   input  logic [31:0]  dc2mem_rdata,
   output logic [31:0]  dc_stat_hits,
   output logic [31:0]  dc_stat_misses
);

   localparam int unsigned TAG_BITS = dc_tag_bits(IDX_BITS);

   logic [1:0]  state_q, state_d;
   logic [29:0] addr_q, addr_d;
   logic [3:0]  wmask_q, wmask_d;
   logic [31:0] wdata_q, wdata_d;
   logic        rd_req_q, rd_req_d;
   logic        wr_req_q, wr_req_d;

   logic [29:0]         look_addr;
   logic                arr_valid;
   logic [TAG_BITS-1:0] arr_tag;
   logic [31:0]         arr_data;
   logic                hit, is_read, idle_rd_hit, idle_rd_miss, fill_ack, wr_ack;

   // In IDLE look up the live request; while a backing op is open use the captured address.
   assign look_addr    = (state_q == ST_IDLE) ? mem2dc_paddr : addr_q;
   assign hit          = arr_valid && (arr_tag == look_addr[29:IDX_BITS]);
   assign is_read      = (mem2dc_write == DC_RD_MASK);
   assign idle_rd_hit  = (state_q == ST_IDLE) && mem2dc_valid && is_read && hit;
   assign idle_rd_miss = (state_q == ST_IDLE) && mem2dc_valid && is_read && !hit;
   assign fill_ack     = (state_q == ST_FILL) && dc2mem_ack;
   assign wr_ack       = (state_q == ST_WRITE) && dc2mem_ack;

   mcpu_core_dcache_array #(
      .IDX_BITS (IDX_BITS)
   ) u_array (
      .clk_i      (clkrst_core_clk),
      .rst_ni     (clkrst_core_rst_n),
      .rd_idx_i   (look_addr[IDX_BITS-1:0]),
      .rd_valid_o (arr_valid),
      .rd_tag_o   (arr_tag),
      .rd_data_o  (arr_data),
      .wr_en_i    (fill_ack || (wr_ack && hit)),
      .wr_fill_i  (fill_ack),
      .wr_idx_i   (addr_q[IDX_BITS-1:0]),
      .wr_be_i    (fill_ack ? 4'hF : wmask_q),
      .wr_tag_i   (addr_q[29:IDX_BITS]),
      .wr_data_i  (fill_ack ? dc2mem_rdata : wdata_q)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wmask_d  = wmask_q;
      wdata_d  = wdata_q;
      rd_req_d = rd_req_q;
      wr_req_d = wr_req_q;
      case (state_q)
         ST_IDLE: begin
            if (idle_rd_miss) begin
               state_d  = ST_FILL;
               rd_req_d = 1'b1;
               addr_d   = mem2dc_paddr;
            end else if (mem2dc_valid && !is_read) begin
               state_d  = ST_WRITE;
               wr_req_d = 1'b1;
               addr_d   = mem2dc_paddr;
               wmask_d  = mem2dc_write;
               wdata_d  = mem2dc_data;
            end
         end
         ST_FILL: begin
            if (dc2mem_ack) begin
               state_d  = ST_IDLE;
               rd_req_d = 1'b0;
            end
         end
         ST_WRITE: begin
            if (dc2mem_ack) begin
               state_d  = ST_WDONE;
               wr_req_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
      if (!clkrst_core_rst_n) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         wmask_q  <= '0;
         wdata_q  <= '0;
         rd_req_q <= 1'b0;
         wr_req_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wmask_q  <= wmask_d;
         wdata_q  <= wdata_d;
         rd_req_q <= rd_req_d;
         wr_req_q <= wr_req_d;
      end
   end

   assign mem2dc_done   = idle_rd_hit || (state_q == ST_WDONE);
   assign mem2dc_data   = idle_rd_hit ? arr_data : 32'bz;
   assign dc2mem_addr   = addr_q;
   assign dc2mem_rd_req = rd_req_q;
   assign dc2mem_wr_req = wr_req_q;
   assign dc2mem_wmask  = wmask_q;
   assign dc2mem_wdata  = wdata_q;

`ifdef MCPU_DCACHE_STATS_EN
   logic [31:0] hits_q, misses_q;
   logic        hold_q;
   logic [29:0] hold_addr_q;
   logic        count_hit;

   // A held request keeps done high for many cycles, and the post-fill hit is the miss itself.
   assign count_hit = idle_rd_hit && !(hold_q && (mem2dc_paddr == hold_addr_q));

   always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
      if (!clkrst_core_rst_n) begin
         hits_q      <= '0;
         misses_q    <= '0;
         hold_q      <= 1'b0;
         hold_addr_q <= '0;
      end else begin
         if (count_hit) hits_q <= sat_inc(hits_q);
         if (idle_rd_miss) misses_q <= sat_inc(misses_q);
         hold_q      <= idle_rd_hit || fill_ack;
         hold_addr_q <= fill_ack ? addr_q : mem2dc_paddr;
      end
   end

   assign dc_stat_hits   = hits_q;
   assign dc_stat_misses = misses_q;
`else
   assign dc_stat_hits   = 32'h0;
   assign dc_stat_misses = 32'h0;
`endif

endmodule

// File: tb/tb_mcpu_core_dcache.sv
// Self-checking bench for mcpu_core_dcache: directed vector table, reset corner, random traffic.
module tb_mcpu_core_dcache;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [29:0] paddr = '0;
   logic [3:0]  wmask_in = '0;
   logic        valid = 1'b0;
   logic [31:0] tb_wdata = '0;
   wire  [31:0] mem_data;
   logic        done;
   logic [29:0] m_addr;
   logic        rd_req, wr_req;
   logic [3:0]  m_wmask;
   logic [31:0] m_wdata;
   logic        ack = 1'b0;
   logic [31:0] rdata = '0;
   logic [31:0] st_hits, st_misses;

   always #5 clk = ~clk;

   assign mem_data = (valid && wmask_in != 4'b0000) ? tb_wdata : 32'bz;

   mcpu_core_dcache #(
      .IDX_BITS (6)
   ) dut (
      .clkrst_core_clk   (clk),
      .clkrst_core_rst_n (rst_n),
      .mem2dc_paddr      (paddr),
      .mem2dc_write      (wmask_in),
      .mem2dc_valid      (valid),
      .mem2dc_done       (done),
      .mem2dc_data       (mem_data),
      .dc2mem_addr       (m_addr),
      .dc2mem_rd_req     (rd_req),
      .dc2mem_wr_req     (wr_req),
      .dc2mem_wmask      (m_wmask),
      .dc2mem_wdata      (m_wdata),
      .dc2mem_ack        (ack),
      .dc2mem_rdata      (rdata),
      .dc_stat_hits      (st_hits),
      .dc_stat_misses    (st_misses)
   );

   int checks = 0;
   int errors = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Backing memory (written by DUT traffic) and reference memory (written by the model).
   logic [31:0] bmem    [int unsigned];
   logic [31:0] ref_mem [int unsigned];

   function automatic logic [31:0] init_word(input logic [29:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] bmem_rd(input logic [29:0] a);
      return bmem.exists(32'(a)) ? bmem[32'(a)] : init_word(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [29:0] a);
      return ref_mem.exists(32'(a)) ? ref_mem[32'(a)] : init_word(a);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   // Backing responder: ack after `lat` cycles of a held request, one-cycle pulse.
   int lat = 1;
   initial begin : responder
      int wcnt;
      wcnt = 0;
      forever begin
         @(negedge clk);
         if (ack) begin
            ack = 1'b0;
         end else if ((rd_req || wr_req) && rst_n) begin
            wcnt++;
            if (wcnt >= lat) begin
               wcnt = 0;
               ack  = 1'b1;
               if (wr_req) bmem[32'(m_addr)] = merge(bmem_rd(m_addr), m_wdata, m_wmask);
               else rdata = bmem_rd(m_addr);
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   // One request from a negedge; returns data, cycles until done, and observed backing traffic.
   task automatic do_req(input logic [29:0] a, input logic [3:0] m, input logic [31:0] d,
                         input int l, output logic [31:0] got, output int cyc,
                         output bit saw_rd, output bit saw_wr, output logic [3:0] seen_mask,
                         output logic [31:0] seen_wdata, output logic [29:0] seen_addr);
      bit finished;
      lat = l; paddr = a; wmask_in = m; tb_wdata = d; valid = 1'b1;
      got = '0; cyc = 0; saw_rd = 0; saw_wr = 0; finished = 0;
      seen_mask = '0; seen_wdata = '0; seen_addr = '0;
      for (int n = 0; n < 60; n++) begin
         #1;
         if (rd_req || wr_req) seen_addr = m_addr;
         if (rd_req) saw_rd = 1;
         if (wr_req) begin
            saw_wr = 1; seen_mask = m_wmask; seen_wdata = m_wdata;
         end
         if (done) begin
            finished = 1; cyc = n;
            if (m == 4'b0000) got = mem_data;
            break;
         end
         @(negedge clk);
      end
      if (!finished) begin
         checks++; errors++;
         $display("FAIL timeout addr=%h actual=no_done required=done", a);
         cyc = -1;
      end
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0; wmask_in = '0;
      @(negedge clk);
   endtask

   typedef struct {
      logic [29:0] addr;
      logic [3:0]  mask;
      logic [31:0] wdata;
      int          lat;
      logic [31:0] exp_data;
      int          exp_cyc;
      bit          exp_rd;
      bit          exp_wr;
   } vec_t;

   vec_t vecs[10];

   initial begin : main
      logic [31:0] got;
      int          cyc;
      bit          srd, swr;
      logic [3:0]  smask;
      logic [31:0] swdata;
      logic [29:0] saddr;
      bit          mv [64];
      int          mt [64];
      int          mhit, mmiss;

      bmem[32'h100] = 32'hDEAD_BEEF;
      vecs[0] = '{30'h100, 4'b0000, 32'h0,         3, 32'hDEAD_BEEF,      4, 1, 0};
      vecs[1] = '{30'h100, 4'b0000, 32'h0,         3, 32'hDEAD_BEEF,      0, 0, 0};
      vecs[2] = '{30'h100, 4'b0010, 32'h0000_AA00, 2, 32'h0,              3, 0, 1};
      vecs[3] = '{30'h100, 4'b0000, 32'h0,         2, 32'hDEAD_AAEF,      0, 0, 0};
      vecs[4] = '{30'h240, 4'b1111, 32'h1234_5678, 1, 32'h0,              2, 0, 1};
      vecs[5] = '{30'h240, 4'b0000, 32'h0,         1, 32'h1234_5678,      2, 1, 0};
      vecs[6] = '{30'h005, 4'b0000, 32'h0,         2, init_word(30'h005), 3, 1, 0};
      vecs[7] = '{30'h045, 4'b0000, 32'h0,         2, init_word(30'h045), 3, 1, 0};
      vecs[8] = '{30'h005, 4'b0000, 32'h0,         2, init_word(30'h005), 3, 1, 0};
      vecs[9] = '{30'h045, 4'b0000, 32'h0,         2, init_word(30'h045), 3, 1, 0};

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check32("rst_done", {31'b0, done}, 32'h0);
      check32("rst_rd_req", {31'b0, rd_req}, 32'h0);
      check32("rst_wr_req", {31'b0, wr_req}, 32'h0);
      check32("rst_addr", {2'b0, m_addr}, 32'h0);
      check32("rst_wmask", {28'b0, m_wmask}, 32'h0);
      check32("rst_wdata", m_wdata, 32'h0);
      check32("rst_hits", st_hits, 32'h0);
      check32("rst_misses", st_misses, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vector table
      for (int i = 0; i < 10; i++) begin
         do_req(vecs[i].addr, vecs[i].mask, vecs[i].wdata, vecs[i].lat,
                got, cyc, srd, swr, smask, swdata, saddr);
         check32($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
         check32($sformatf("vec%0d_rd_req", i), {31'b0, srd}, {31'b0, vecs[i].exp_rd});
         check32($sformatf("vec%0d_wr_req", i), {31'b0, swr}, {31'b0, vecs[i].exp_wr});
         if (vecs[i].mask == 4'b0000) begin
            check32($sformatf("vec%0d_data", i), got, vecs[i].exp_data);
         end else begin
            check32($sformatf("vec%0d_wmask", i), {28'b0, smask}, {28'b0, vecs[i].mask});
            check32($sformatf("vec%0d_wdata", i), swdata, vecs[i].wdata);
         end
         if (vecs[i].exp_rd || vecs[i].exp_wr)
            check32($sformatf("vec%0d_addr", i), {2'b0, saddr}, {2'b0, vecs[i].addr});
      end
`ifdef MCPU_DCACHE_STATS_EN
      check32("tbl_hits", st_hits, 32'd2);
      check32("tbl_misses", st_misses, 32'd6);
`else
      check32("tbl_hits", st_hits, 32'd0);
      check32("tbl_misses", st_misses, 32'd0);
`endif

      // Reset in the middle of a fill
      lat = 20; paddr = 30'h100; wmask_in = 4'b0000; valid = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check32("midfill_rd_req", {31'b0, rd_req}, 32'h1);
      rst_n = 1'b0;
      #1;
      check32("midfill_rd_req_drop", {31'b0, rd_req}, 32'h0);
      check32("midfill_done", {31'b0, done}, 32'h0);
      check32("midfill_misses", st_misses, 32'h0);
      @(negedge clk);
      valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      do_req(30'h100, 4'b0000, 32'h0, 2, got, cyc, srd, swr, smask, swdata, saddr);
      check32("postrst_cycles", 32'(cyc), 32'd3);
      check32("postrst_rd_req", {31'b0, srd}, 32'h1);
      check32("postrst_data", got, 32'hDEAD_AAEF);

      // Random traffic against an abstract model: cache = {valid, tag} per index.
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      ref_mem = bmem;
      for (int k = 0; k < 64; k++) begin mv[k] = 0; mt[k] = 0; end
      mhit = 0; mmiss = 0;
      for (int t = 0; t < 150; t++) begin
         int          idx, tg, l, exp_cyc;
         bit          wr, h;
         logic [29:0] a;
         logic [3:0]  m;
         logic [31:0] d, exp_data;
         idx = $urandom_range(0, 7);
         tg  = $urandom_range(0, 3);
         a   = 30'(tg * 64 + idx);
         wr  = ($urandom_range(0, 9) < 3);
         m   = wr ? 4'($urandom_range(1, 15)) : 4'b0000;
         d   = $urandom;
         l   = $urandom_range(1, 4);
         exp_data = ref_rd(a);
         if (wr) begin
            exp_cyc = l + 1;
            ref_mem[32'(a)] = merge(ref_rd(a), d, m);
         end else begin
            h = mv[idx] && (mt[idx] == tg);
            exp_cyc = h ? 0 : l + 1;
            if (h) mhit++;
            else begin mmiss++; mv[idx] = 1; mt[idx] = tg; end
         end
         do_req(a, m, d, l, got, cyc, srd, swr, smask, swdata, saddr);
         check32($sformatf("rnd%0d_cycles", t), 32'(cyc), 32'(exp_cyc));
         if (!wr) check32($sformatf("rnd%0d_data", t), got, exp_data);
      end
`ifdef MCPU_DCACHE_STATS_EN
      check32("rnd_hits", st_hits, 32'(mhit));
      check32("rnd_misses", st_misses, 32'(mmiss));
`else
      check32("rnd_hits", st_hits, 32'd0);
      check32("rnd_misses", st_misses, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
